// File: rtl/ikaopll_bus_writer.sv
// Host-side write sequencer for the IKAOPLL bus: queues (address, data) pairs and
// replays each as a timed address-write / data-write cycle counted in phiM enables.
module ikaopll_bus_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_PULSE   = 2,
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84
) (
  input  logic                          i_EMUCLK,
  input  logic                          i_RST_n,
  input  logic                          i_phiM_PCEN_n,
  input  logic                          i_WREQ_VALID,
  output logic                          o_WREQ_READY,
  input  logic [7:0]                    i_WREQ_ADDR,
  input  logic [7:0]                    i_WREQ_DATA,
  output logic                          o_CS_n,
  output logic                          o_WR_n,
  output logic                          o_A0,
  output logic [7:0]                    o_D,
  output logic                          o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   o_LEVEL
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned MAX_A   = (WR_PULSE > ADDR_WAIT) ? WR_PULSE : ADDR_WAIT;
  localparam int unsigned MAX_DUR = (MAX_A > DATA_WAIT) ? MAX_A : DATA_WAIT;
  localparam int unsigned CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  // Counter holds "remaining enabled edges minus one" for the current phase.
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] AW_LOAD = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DW_LOAD = CNT_W'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_PULSE,
    S_ADDR_WAIT,
    S_DATA_PULSE,
    S_DATA_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_n_q, bus_n_d;
  logic               a0_q, a0_d;
  logic [7:0]         d_q, d_d;
  logic [7:0]         hold_q, hold_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        head_c;
  logic               phi_en_c, push_c, pop_c, start_c;

  assign phi_en_c = ~i_phiM_PCEN_n;
  assign push_c   = i_WREQ_VALID & ready_q;
  assign head_c   = mem_q[rd_ptr_q];

  // Next-state and bus outputs; a pair start is shared by IDLE and DATA_WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_n_d = bus_n_q;
    a0_d    = a0_q;
    d_d     = d_q;
    hold_d  = hold_q;
    start_c = 1'b0;
    if (phi_en_c) begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) start_c = 1'b1;
        end
        S_ADDR_PULSE: begin
          if (cnt_q == '0) begin
            state_d = S_ADDR_WAIT;
            cnt_d   = AW_LOAD;
            bus_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_ADDR_WAIT: begin
          if (cnt_q == '0) begin
            state_d = S_DATA_PULSE;
            cnt_d   = WR_LOAD;
            bus_n_d = 1'b0;
            a0_d    = 1'b1;
            d_d     = hold_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DATA_PULSE: begin
          if (cnt_q == '0) begin
            state_d = S_DATA_WAIT;
            cnt_d   = DW_LOAD;
            bus_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DATA_WAIT: begin
          if (cnt_q == '0) begin
            if (level_q != '0) start_c = 1'b1;
            else               state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pop_c = start_c;
    if (start_c) begin
      state_d = S_ADDR_PULSE;
      cnt_d   = WR_LOAD;
      bus_n_d = 1'b0;
      a0_d    = 1'b0;
      d_d     = head_c[15:8];
      hold_d  = head_c[7:0];
    end
  end

  // Occupancy and status flags follow the next-state values so they stay registered.
  always_comb begin
    level_d = level_q;
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) | (level_d != '0);
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bus_n_q  <= 1'b1;
      a0_q     <= 1'b0;
      d_q      <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_n_q <= bus_n_d;
      a0_q    <= a0_d;
      d_q     <= d_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge i_EMUCLK) begin
    if (push_c) mem_q[wr_ptr_q] <= {i_WREQ_ADDR, i_WREQ_DATA};
  end

  assign o_CS_n       = bus_n_q;
  assign o_WR_n       = bus_n_q;
  assign o_A0         = a0_q;
  assign o_D          = d_q;
  assign o_WREQ_READY = ready_q;
  assign o_BUSY       = busy_q;
  assign o_LEVEL      = level_q;

endmodule

// File: tb/tb_ikaopll_bus_writer.sv
// Directed bench for ikaopll_bus_writer: default-timing instance plus a
// minimum-timing instance, checked against hand-derived phase lengths.
module tb_ikaopll_bus_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       pcen = 1'b0;
  logic       tog = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] addr = '0, data = '0;
  logic       ready, cs, wr, a0, busy;
  logic [7:0] d;
  logic [2:0] level;

  logic       v2 = 1'b0;
  logic [7:0] a2 = '0, dt2 = '0;
  logic       rdy2, cs2, wr2, a02, busy2;
  logic [7:0] dd2;
  logic [2:0] lvl2;

  int n_checks = 0;
  int n_fail   = 0;

  ikaopll_bus_writer dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen),
    .i_WREQ_VALID(valid), .o_WREQ_READY(ready),
    .i_WREQ_ADDR(addr), .i_WREQ_DATA(data),
    .o_CS_n(cs), .o_WR_n(wr), .o_A0(a0), .o_D(d),
    .o_BUSY(busy), .o_LEVEL(level)
  );

  ikaopll_bus_writer #(.FIFO_DEPTH(4), .WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1)) dut2 (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen),
    .i_WREQ_VALID(v2), .o_WREQ_READY(rdy2),
    .i_WREQ_ADDR(a2), .i_WREQ_DATA(dt2),
    .o_CS_n(cs2), .o_WR_n(wr2), .o_A0(a02), .o_D(dd2),
    .o_BUSY(busy2), .o_LEVEL(lvl2)
  );

  // phiM enable: tied active, or alternating every clock when tog is set
  always @(posedge clk) begin
    #1;
    pcen = tog ? ~pcen : 1'b0;
  end

  // Caller sits just after a posedge; returns just after the accepting edge.
  task automatic push_pair(input logic [7:0] pa, input logic [7:0] pd);
    int   w;
    logic r;
    valid = 1'b1; addr = pa; data = pd;
    w = 0;
    do begin
      @(negedge clk); r = ready;
      @(posedge clk); w++;
    end while (!r && w < 400);
    #1 valid = 1'b0;
    n_checks++;
    if (!r) begin n_fail++; $display("FAIL push_timeout addr=%02h", pa); end
  endtask

  task automatic wait_cs_low(input string name, output int n);
    n = 0;
    if (cs !== 1'b0) begin
      do begin @(negedge clk); n++; end while (cs !== 1'b0 && n < 1000);
    end
    n_checks++;
    if (cs !== 1'b0) begin n_fail++; $display("FAIL %s cs_fall_timeout cs=%b", name, cs); end
  endtask

  task automatic measure(input logic lvl, input bit last, input int bound,
                         output int len, output bit chg);
    logic       a0s;
    logic [7:0] ds;
    len = 0; chg = 1'b0; a0s = a0; ds = d;
    while (cs === lvl && (!last || busy === 1'b1) && len < bound) begin
      if (wr !== cs || a0 !== a0s || d !== ds) chg = 1'b1;
      @(negedge clk);
      len++;
    end
  endtask

  task automatic check_len(input string name, input int got, input int exp, input bit chg);
    n_checks++;
    if (got !== exp || chg) begin
      n_fail++;
      $display("FAIL %s len=%0d changed=%0b, expected len=%0d changed=0", name, got, chg, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic ea0, input logic [7:0] ed);
    n_checks++;
    if (a0 !== ea0 || d !== ed) begin
      n_fail++;
      $display("FAIL %s a0=%b d=%02h, expected a0=%b d=%02h", name, a0, d, ea0, ed);
    end
  endtask

  // Follows one full address/data write from the CS_n fall onward.
  task automatic check_write(input string name, input logic [7:0] pa, input logic [7:0] pd,
                             input int lp, input int aw, input int dw, input bit last);
    int n, len;
    bit chg;
    wait_cs_low(name, n);
    check_bus({name, "_addr"}, 1'b0, pa);
    measure(1'b0, 1'b0, lp + 20, len, chg); check_len({name, "_addr_pulse"}, len, lp, chg);
    check_bus({name, "_addr_hold"}, 1'b0, pa);
    measure(1'b1, 1'b0, aw + 20, len, chg); check_len({name, "_addr_wait"}, len, aw, chg);
    check_bus({name, "_data"}, 1'b1, pd);
    measure(1'b0, 1'b0, lp + 20, len, chg); check_len({name, "_data_pulse"}, len, lp, chg);
    measure(1'b1, last, dw + 20, len, chg); check_len({name, "_data_wait"}, len, dw, chg);
    if (last) begin
      n_checks++;
      if (busy !== 1'b0 || cs !== 1'b1 || level !== 3'd0) begin
        n_fail++;
        $display("FAIL %s_idle busy=%b cs=%b level=%0d, expected 0 1 0", name, busy, cs, level);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (cs !== 1'b1 || wr !== 1'b1 || a0 !== 1'b0 || d !== 8'h00 ||
        level !== 3'd0 || ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state cs=%b wr=%b a0=%b d=%02h lvl=%0d rdy=%b busy=%b, expected 1 1 0 00 0 1 0",
               cs, wr, a0, d, level, ready, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int n;
    push_pair(8'h10, 8'hAB);
    n_checks++;
    if (busy !== 1'b1 || level !== 3'd1) begin
      n_fail++; $display("FAIL single_queued busy=%b level=%0d, expected 1 1", busy, level);
    end
    // Push edge, then one enabled edge drives CS_n low: second negedge after the push.
    wait_cs_low("single_latency", n);
    n_checks++;
    if (n !== 2) begin n_fail++; $display("FAIL single_latency negedges=%0d, expected 2", n); end
    check_write("single", 8'h10, 8'hAB, 2, 12, 84, 1'b1);
  endtask

  task automatic test_enable_toggle();
    @(posedge clk); #1 tog = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_pair(8'h10, 8'hAB);
    check_write("toggle", 8'h10, 8'hAB, 4, 24, 168, 1'b1);
    tog = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [5];
    logic [7:0] pd [5];
    pa = '{8'h30, 8'h31, 8'h32, 8'h20, 8'h0E};
    pd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fork
      begin
        for (int i = 0; i < 5; i++) push_pair(pa[i], pd[i]);
        @(negedge clk);
        n_checks++;
        if (level !== 3'd4 || ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_full level=%0d ready=%b, expected 4 0", level, ready);
        end
      end
      begin
        for (int k = 0; k < 5; k++)
          check_write($sformatf("b2b_pair%0d", k), pa[k], pd[k], 2, 12, 84, k == 4);
      end
    join
  endtask

  task automatic test_full_push_on_pop();
    int n;
    for (int i = 0; i < 5; i++) push_pair(8'h40 + 8'(i), 8'h60 + 8'(i));
    valid = 1'b1; addr = 8'h45; data = 8'h65;
    @(negedge clk);
    n_checks++;
    if (level !== 3'd4 || ready !== 1'b0) begin
      n_fail++; $display("FAIL full_level level=%0d ready=%b, expected 4 0", level, ready);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (level === 3'd4 && n < 300);
    n_checks++;
    if (level !== 3'd3 || ready !== 1'b1 || cs !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_edge level=%0d ready=%b cs=%b, expected 3 1 0", level, ready, cs);
    end
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (level !== 3'd4 || ready !== 1'b0) begin
      n_fail++; $display("FAIL full_refill level=%0d ready=%b, expected 4 0", level, ready);
    end
    n = 0;
    while (busy !== 1'b0 && n < 800) begin @(negedge clk); n++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_drain busy=%b, expected 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    push_pair(8'h31, 8'h44);
    push_pair(8'h32, 8'h55);
    n = 0;
    while (cs !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    while (cs !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    while (cs !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check_bus("rst_in_data_pulse", 1'b1, 8'h44);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cs !== 1'b1 || wr !== 1'b1 || a0 !== 1'b0 || d !== 8'h00 || level !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort cs=%b wr=%b a0=%b d=%02h lvl=%0d busy=%b, expected 1 1 0 00 0 0",
               cs, wr, a0, d, level, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_pair(8'h20, 8'h5A);
    check_write("after_rst", 8'h20, 8'h5A, 2, 12, 84, 1'b1);
  endtask

  task automatic test_min_timing();
    logic [7:0] pa [3];
    logic [7:0] pd [3];
    pa = '{8'h01, 8'h02, 8'h03};
    pd = '{8'hC1, 8'hC2, 8'hC3};
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          v2 = 1'b1; a2 = pa[i]; dt2 = pd[i];
          @(posedge clk); #1;
        end
        v2 = 1'b0;
      end
      begin
        int         n;
        int         ph;
        logic       ecs, ea0;
        logic [7:0] ed;
        n = 0;
        while (cs2 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        for (int k = 0; k < 12; k++) begin
          ph  = k % 4;
          ecs = (ph == 1 || ph == 3);
          ea0 = (ph >= 2);
          ed  = (ph < 2) ? pa[k / 4] : pd[k / 4];
          n_checks++;
          if (cs2 !== ecs || wr2 !== ecs || a02 !== ea0 || dd2 !== ed) begin
            n_fail++;
            $display("FAIL min_cycle%0d cs=%b wr=%b a0=%b d=%02h, expected cs=wr=%b a0=%b d=%02h",
                     k, cs2, wr2, a02, dd2, ecs, ea0, ed);
          end
          @(negedge clk);
        end
        n_checks++;
        if (busy2 !== 1'b0 || cs2 !== 1'b1) begin
          n_fail++; $display("FAIL min_idle busy=%b cs=%b, expected 0 1", busy2, cs2);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_enable_toggle();
    test_back_to_back();
    test_full_push_on_pop();
    test_reset_mid_transfer();
    @(posedge clk); #1;
    test_min_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
